div_iter: RTL and testbench

Iterative 32-bit integer divider that answers the ALU's `validIn`/`validOut` multiply/divide handshake.
- The ALU holds `validIn` and stalls the pipeline.
- This block latches the operands and runs a radix-2 restoring division.
- It returns quotient on `Lo` and remainder on `Hi` with a one-cycle `validOut` pulse.
- It sits beside the multiplier under the ALU wrapper and feeds the HI/LO register writes for DIV/DIVU.

---
 rtl/div_iter_if.sv | 23 ++
 rtl/div_iter.sv | 116 +++++++++++
 tb/tb_div_iter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Handshake and operand/result bundle between the ALU wrapper (master) and div_iter (slave).
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             i_validIn;
    logic             i_sign;
    logic [WIDTH-1:0] i_SrcA;
    logic [WIDTH-1:0] i_SrcB;
    logic [WIDTH-1:0] o_Hi;
    logic [WIDTH-1:0] o_Lo;
    logic             o_validOut;
    logic             o_busy;

    modport master (
        output i_validIn, i_sign, i_SrcA, i_SrcB,
        input  o_Hi, o_Lo, o_validOut, o_busy
    );

    modport slave (
        input  i_validIn, i_sign, i_SrcA, i_SrcB,
        output o_Hi, o_Lo, o_validOut, o_busy
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: quotient on Lo, remainder on Hi.
// Optional macro DIV_EARLY_OUT_EN finishes divide-by-zero and |divisor| > |dividend| at the start edge.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_iter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [5:0]       r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_negQ;
    logic             r_negR;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_negA;
    logic             w_negB;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    // A zero divisor counts as non-negative, so a negative dividend flips the all-ones quotient to 1.
    assign w_negA = bus.i_sign & bus.i_SrcA[WIDTH-1];
    assign w_negB = bus.i_sign & bus.i_SrcB[WIDTH-1];
    assign w_absA = w_negA ? -bus.i_SrcA : bus.i_SrcA;
    assign w_absB = w_negB ? -bus.i_SrcB : bus.i_SrcB;

    // The shifted remainder needs one extra bit; its top bit of the difference is the borrow.
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_remShift - {1'b0, r_divisor};
    assign w_remNext  = w_diff[WIDTH] ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quoNext  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

`ifdef DIV_EARLY_OUT_EN
    logic             w_divZero;
    logic             w_earlyOut;
    logic [WIDTH-1:0] w_earlyLo;

    assign w_divZero  = (bus.i_SrcB == '0);
    assign w_earlyOut = w_divZero || (w_absB > w_absA);
    assign w_earlyLo  = !w_divZero ? '0 :
                        w_negA     ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_validIn) begin
                        r_negQ    <= w_negA ^ w_negB;
                        r_negR    <= w_negA;
                        r_rem     <= '0;
                        r_quo     <= w_absA;
                        r_divisor <= w_absB;
                        r_count   <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (w_earlyOut) begin
                            r_hi    <= bus.i_SrcA;
                            r_lo    <= w_earlyLo;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
`else
                        r_state   <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    r_rem   <= w_remNext;
                    r_quo   <= w_quoNext;
                    r_count <= r_count + 6'd1;
                    // Sign fix-up rides on the final iteration so DONE already shows the answer.
                    if (r_count == LAST_ITER) begin
                        r_hi    <= r_negR ? -w_remNext : w_remNext;
                        r_lo    <= r_negQ ? -w_quoNext : w_quoNext;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Hi       = r_hi;
    assign bus.o_Lo       = r_lo;
    assign bus.o_validOut = (r_state == S_DONE);
    assign bus.o_busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random operands against a plain-arithmetic model.
module tb_div_iter;
    logic clk;
    logic reset;
    int   nChecks;
    int   nErrors;
    int   cyc;
    int   lastDoneCyc;
    logic [31:0] tbLastHi;
    logic [31:0] tbLastLo;

    div_iter_if #(.WIDTH(32)) dif ();

    div_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model straight from the arithmetic rules of DIV/DIVU.
    task automatic modelDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            r = a;
            q = (s && $signed(a) < 0) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end
    endtask

    function automatic int expectedLatency(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b == 32'd0 || mb > ma) return 1;
`endif
        return 33;
    endfunction

    // Called at a negedge with validIn low; returns at the negedge after the DONE cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input bit holdInDone, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int lat;
        int expLat;
        modelDiv(a, b, s, eq, er);
        expLat = expectedLatency(a, b, s);
        dif.i_SrcA    = a;
        dif.i_SrcB    = b;
        dif.i_sign    = s;
        dif.i_validIn = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                dif.i_SrcA = $urandom;
                dif.i_SrcB = $urandom;
                dif.i_sign = 1'($urandom);
                checkOutput({tag, ".busyStart"}, 64'(dif.o_busy), 64'd1);
                if (expLat > 1) begin
                    checkOutput({tag, ".holdHi"}, 64'(dif.o_Hi), 64'(tbLastHi));
                    checkOutput({tag, ".holdLo"}, 64'(dif.o_Lo), 64'(tbLastLo));
                end
            end
        end while (!dif.o_validOut && lat < 100);
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, ".Lo"}, 64'(dif.o_Lo), 64'(eq));
        checkOutput({tag, ".Hi"}, 64'(dif.o_Hi), 64'(er));
        lastDoneCyc = cyc;
        tbLastHi = er;
        tbLastLo = eq;
        if (!holdInDone) dif.i_validIn = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".pulseEnd"}, 64'(dif.o_validOut), 64'd0);
        checkOutput({tag, ".busyEnd"}, 64'(dif.o_busy), 64'd0);
        dif.i_validIn = 1'b0;
    endtask

    initial begin
        int t1;
        bit sawValid;
        logic [31:0] ra;
        logic [31:0] rb;
        int mode;
        nChecks = 0;
        nErrors = 0;
        cyc = 0;
        tbLastHi = '0;
        tbLastLo = '0;
        reset = 1'b1;
        dif.i_validIn = 1'b0;
        dif.i_sign = 1'b0;
        dif.i_SrcA = '0;
        dif.i_SrcB = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 64'(dif.o_busy), 64'd0);
        checkOutput("reset.validOut", 64'(dif.o_validOut), 64'd0);
        checkOutput("reset.Hi", 64'(dif.o_Hi), 64'd0);
        checkOutput("reset.Lo", 64'(dif.o_Lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1, "u100div7");
        applyStimulus(-32'sd7, 32'd2, 1'b1, 1'b0, "sNeg7div2");
        applyStimulus(32'd7, -32'sd2, 1'b1, 1'b0, "s7divNeg2");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "sMinDivNeg1");
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b0, "u5div0");
        applyStimulus(-32'sd5, 32'd0, 1'b1, 1'b0, "sNeg5div0");
        applyStimulus(32'd5, 32'd0, 1'b1, 1'b0, "s5div0");

        $display("[TB] reset during division");
        dif.i_SrcA = 32'd1000;
        dif.i_SrcB = 32'd3;
        dif.i_sign = 1'b0;
        dif.i_validIn = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midReset.busy", 64'(dif.o_busy), 64'd0);
        checkOutput("midReset.validOut", 64'(dif.o_validOut), 64'd0);
        checkOutput("midReset.Hi", 64'(dif.o_Hi), 64'd0);
        checkOutput("midReset.Lo", 64'(dif.o_Lo), 64'd0);
        reset = 1'b0;
        dif.i_validIn = 1'b0;
        tbLastHi = '0;
        tbLastLo = '0;
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.o_validOut) sawValid = 1'b1;
        end
        checkOutput("midReset.noPulse", 64'(sawValid), 64'd0);
        applyStimulus(32'd9, 32'd3, 1'b0, 1'b0, "u9div3");

        $display("[TB] back-to-back");
        applyStimulus(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0, "b2bFirst");
        t1 = lastDoneCyc;
        applyStimulus(32'd12, 32'd5, 1'b0, 1'b0, "b2bSecond");
        checkOutput("b2b.spacing", 64'(lastDoneCyc - t1), 64'd34);

        $display("[TB] reset and validIn together");
        reset = 1'b1;
        dif.i_validIn = 1'b1;
        @(negedge clk);
        checkOutput("resetWins.busy", 64'(dif.o_busy), 64'd0);
        reset = 1'b0;
        dif.i_validIn = 1'b0;
        tbLastHi = '0;
        tbLastLo = '0;
        @(negedge clk);

        $display("[TB] random operands");
        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 4));
            ra = $urandom;
            rb = $urandom;
            case (mode)
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'd0;
                3: begin ra = 32'($urandom_range(0, 1000)); rb = ra + 32'($urandom_range(1, 50)); end
                4: begin ra = -32'($urandom_range(1, 5000)); rb = -32'($urandom_range(1, 70)); end
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom), 1'b0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
